// File: rtl/decoder_scan_nx.sv
// rtl/decoder_scan_nx.sv - N-to-2^N one-hot decoder with registered output, enable and autonomous scan
//
// Purpose:
//   Drives one of 2^N load-select lines (digit selects, row strobes).
//   DIRECT mode decodes i with one cycle of latency. SCAN mode walks the
//   active line through every index, holding each for dwell+1 cycles.
//   All outputs are registered; no input reaches an output combinationally.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst_n  in   1          asynchronous active-low reset
//   en     in   1          output enable; 0 forces d to all-zero, idx/cnt hold
//   mode   in   1          0 = direct decode, 1 = scan
//   i      in   N          direct select / scan load index
//   load   in   1          scan only: restart the scan at i
//   dwell  in   DWELL_W    each scan index is held dwell+1 cycles
//   d      out  2^N        registered one-hot output
//   idx    out  N          current index register
//   wrap   out  1          one-cycle pulse when the scan wraps 2^N-1 -> 0

module decoder_scan_nx #(
   parameter int N       = 2,
   parameter int DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic [N-1:0]         i,
   input  logic                 load,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [(1<<N)-1:0]    d,
   output logic [N-1:0]         idx,
   output logic                 wrap
);

   localparam int LINES = 1 << N;
   localparam logic [N-1:0]       IDX_LAST = '1;
   localparam logic [DWELL_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t             state;
   logic [DWELL_W-1:0] cnt;

   logic [N-1:0]       scan_idx;
   logic [DWELL_W-1:0] scan_cnt;
   logic               scan_wrap;
   logic               advance;

   function automatic logic [LINES-1:0] onehot(input logic [N-1:0] sel);
      logic [LINES-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

   // Operating state is purely a decode of en/mode; there is no stored FSM
   // state, so a mode change takes effect on the very next edge.
   always_comb begin
      state = ST_OFF;
      if (en) begin
         state = mode ? ST_SCAN : ST_DIRECT;
      end
   end

   // Greater-or-equal rather than equality: lowering dwell below the current
   // count forces an advance on the next edge instead of stalling the scan.
   assign advance = (cnt >= dwell);

   always_comb begin
      scan_idx  = idx;
      scan_cnt  = cnt;
      scan_wrap = 1'b0;
      if (load) begin
         scan_idx = i;
         scan_cnt = '0;
      end else if (advance) begin
         scan_idx  = idx + 1'b1;
         scan_cnt  = '0;
         scan_wrap = (idx == IDX_LAST);
      end else if (cnt != CNT_MAX) begin
         // cnt < dwell <= CNT_MAX here, so the guard never blocks a real
         // increment; it only documents that cnt cannot roll over.
         scan_cnt = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d    <= '0;
         idx  <= '0;
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         case (state)
            ST_DIRECT: begin
               idx  <= i;
               cnt  <= '0;
               wrap <= 1'b0;
               d    <= onehot(i);
            end
            ST_SCAN: begin
               idx  <= scan_idx;
               cnt  <= scan_cnt;
               wrap <= scan_wrap;
               d    <= onehot(scan_idx);
            end
            default: begin
               // OFF: blank the output but keep idx/cnt so the scan resumes
               // exactly where it paused.
               d    <= '0;
               wrap <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/decoder_scan_nx.md
# decoder_scan_nx

Parametrised N-to-2^N one-hot decoder with a registered output, an enable and an autonomous scan mode. In direct mode it decodes `i` with one cycle of latency. In scan mode it walks the active output through all 2^N lines, holding each one for a programmable dwell time. It sits between control logic and multiplexed loads such as 7-segment digit selects or row strobes, and it supersedes the combinational 2x4 decoder.

## Interface
- `N`, default 2: select width; the output is 2^N lines wide.
- `DWELL_W`, default 8: width of the dwell count.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  output enable; 0 forces `d` to all-zero
- `mode`  in  1  0 = direct decode, 1 = scan
- `i`  in  N  select in direct mode; start index for `load` in scan mode
- `load`  in  1  scan mode only: restart the scan at `i`
- `dwell`  in  DWELL_W  each scan index is held `dwell`+1 cycles
- `d`  out  2^N  registered one-hot decode output
- `idx`  out  N  current index register
- `wrap`  out  1  one-cycle pulse when the scan wraps from 2^N-1 to 0

## Operation
- Internal registers:
  - `idx` (N bits)
  - `cnt` (DWELL_W bits)
  - `d`
  - `wrap`
- Every output is registered. No output has a combinational path from any input.
- Reset (`rst_n`=0, asynchronous) clears `d`, `idx`, `cnt` and `wrap` to 0 immediately. Reset asserted mid-scan aborts the scan. After reset is released, the block resumes from index 0 with `cnt`=0.
- Effective states, decoded from `en` and `mode`:
  - OFF (`en`=0): `d`<=0; `idx` and `cnt` hold; `wrap`<=0; `load` is ignored.
  - DIRECT (`en`=1, `mode`=0): `idx`<=`i`; `cnt`<=0; `wrap`<=0; `load` is ignored.
  - SCAN (`en`=1, `mode`=1):
    - Priority 1, `load`=1: `idx`<=`i`, `cnt`<=0, `wrap`<=0.
    - Priority 2, `cnt`>=`dwell`: `cnt`<=0 and `idx`<=`idx`+1 modulo 2^N. `wrap`<=1 only when the old `idx` was 2^N-1; otherwise `wrap`<=0.
    - Otherwise: `cnt`<=`cnt`+1; `idx` holds; `wrap`<=0.
- Whenever `en`=1, `d` <= one-hot of the next `idx`. Exactly one bit is set, at position `idx`, so `d` always equals one-hot(`idx`) while enabled.
- Comparison rule: the advance condition is `cnt`>=`dwell`, not equality. If `dwell` is lowered below the current `cnt`, the scan advances on the next edge and never stalls.
- `dwell`=0: the index advances every cycle.
- `cnt` never exceeds 2^DWELL_W-1, so the counter cannot wrap silently.
- Mode switches:
  - DIRECT->SCAN: the scan starts from the current `idx` with `cnt`=0. The first advance comes `dwell`+1 cycles after the switch edge.
  - SCAN->DIRECT: `idx` takes `i` on the first DIRECT edge.
  - OFF->SCAN: resumes with the held `idx` and `cnt`.
- `wrap` is never asserted on `load`, in DIRECT, or on reset.

## Timing
- DIRECT latency: 1 cycle. `i` sampled at edge k appears on `d` and `idx` after edge k.
- Enable latency: `en` falling at edge k gives `d`=0 after edge k. `en` rising at edge k gives a valid one-hot `d` after edge k.
- SCAN period: 2^N × (`dwell`+1) cycles per full sweep. `wrap` pulses exactly once per sweep, high for one cycle, coincident with `idx`=0.
- `load` takes effect at the sampling edge. The loaded index is held for `dwell`+1 cycles.
- Inputs are synchronous to `clk`. `dwell` may change at any cycle and takes effect at the next compare.

## Test plan
- Reset: assert `rst_n`=0 mid-scan with `idx`=2 → `d`=0000, `idx`=0, `wrap`=0 immediately, with no clock edge needed; after release, the scan restarts at index 0.
- DIRECT with N=2, `en`=0, `i`=00,01,10,11 → `d`=0000 throughout. Then `en`=1, `i`=00,01,10,11 → `d`=0001,0010,0100,1000, each one cycle after `i`.
- SCAN with N=2, `dwell`=2 → `d` holds each of 0001,0010,0100,1000 for 3 cycles. `wrap`=1 for one cycle when `d` returns to 0001; sweep period is 12 cycles.
- SCAN with `dwell`=0 → `d` changes every cycle. `wrap` pulses every 4 cycles.
- SCAN with `load`=1, `i`=10 while `idx`=0 → next cycle `d`=0100 with `cnt` restarted and `wrap`=0. After advancing from 11 to 00, `wrap`=1.
- `dwell` lowered from 7 to 1 while `cnt`=5 → advance on the next edge. `en` dropped for 4 cycles mid-scan → `d`=0000 during the gap, then the scan resumes at the same `idx` and `cnt`.
